// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request and response channel, Z/N/C/V flag register
// and an iterative shift-add multiplier.
module alu_mc #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_func,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [3:0]        flags,
    input  logic              flags_clr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [3:0] F_ADD  = 4'd0;
    localparam logic [3:0] F_SUB  = 4'd1;
    localparam logic [3:0] F_AND  = 4'd2;
    localparam logic [3:0] F_OR   = 4'd3;
    localparam logic [3:0] F_XOR  = 4'd4;
    localparam logic [3:0] F_INV  = 4'd5;
    localparam logic [3:0] F_ADC  = 4'd6;
    localparam logic [3:0] F_SBC  = 4'd7;
    localparam logic [3:0] F_SHL  = 4'd8;
    localparam logic [3:0] F_SHR  = 4'd9;
    localparam logic [3:0] F_SRA  = 4'd10;
    localparam logic [3:0] F_MUL  = 4'd11;
    localparam logic [3:0] F_MULH = 4'd12;

    localparam logic [SHAMT_W-1:0] LAST_STEP = SHAMT_W'(DATA_W - 1);

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [3:0]              flags_q, flags_d;
    logic [2*DATA_W-1:0]     acc_q, acc_d;
    logic [DATA_W-1:0]       mcand_q, mcand_d;
    logic                    mulh_q, mulh_d;
    logic [SHAMT_W-1:0]      cnt_q, cnt_d;

    logic                    accept;
    logic                    cin;
    logic [SHAMT_W-1:0]      shamt;
    logic [DATA_W:0]         add_w, sub_w;
    logic [2*DATA_W-1:0]     shl_w, shr_w;
    logic signed [2*DATA_W-1:0] sra_w;
    logic [DATA_W-1:0]       alu_res;
    logic                    alu_c, alu_v;
    logic                    is_mul, illegal;
    logic [DATA_W:0]         mul_sum;
    logic [2*DATA_W-1:0]     mul_next;
    logic [DATA_W-1:0]       mul_res;
    logic                    mul_cv;

    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign flags     = flags_q;

    assign cin   = flags_q[1];
    assign shamt = req_b[SHAMT_W-1:0];

    // Shifts run on a double-width window so the bit just past the result is the last bit out.
    always_comb begin
        add_w = {1'b0, req_a} + {1'b0, req_b} + {{DATA_W{1'b0}}, (req_func == F_ADC) && cin};
        sub_w = {1'b0, req_a} - {1'b0, req_b} - {{DATA_W{1'b0}}, (req_func == F_SBC) && cin};
        shl_w = {{DATA_W{1'b0}}, req_a} << shamt;
        shr_w = {req_a, {DATA_W{1'b0}}} >> shamt;
        sra_w = $signed({req_a, {DATA_W{1'b0}}}) >>> shamt;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        is_mul  = 1'b0;
        illegal = 1'b0;
        case (req_func)
            F_ADD, F_ADC: begin
                alu_res = add_w[DATA_W-1:0];
                alu_c   = add_w[DATA_W];
                alu_v   = (req_a[DATA_W-1] == req_b[DATA_W-1]) &&
                          (add_w[DATA_W-1] != req_a[DATA_W-1]);
            end
            F_SUB, F_SBC: begin
                alu_res = sub_w[DATA_W-1:0];
                alu_c   = sub_w[DATA_W];
                alu_v   = (req_a[DATA_W-1] != req_b[DATA_W-1]) &&
                          (sub_w[DATA_W-1] != req_a[DATA_W-1]);
            end
            F_AND: alu_res = req_a & req_b;
            F_OR:  alu_res = req_a | req_b;
            F_XOR: alu_res = req_a ^ req_b;
            F_INV: alu_res = ~req_a;
            F_SHL: begin
                alu_res = shl_w[DATA_W-1:0];
                alu_c   = (shamt != '0) && shl_w[DATA_W];
            end
            F_SHR: begin
                alu_res = shr_w[2*DATA_W-1:DATA_W];
                alu_c   = (shamt != '0) && shr_w[DATA_W-1];
            end
            F_SRA: begin
                alu_res = sra_w[2*DATA_W-1:DATA_W];
                alu_c   = (shamt != '0) && sra_w[DATA_W-1];
            end
            F_MUL, F_MULH: is_mul = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the high half, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} +
                   (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
        mul_next = {mul_sum, acc_q[DATA_W-1:1]};
        mul_res  = mulh_q ? mul_next[2*DATA_W-1:DATA_W] : mul_next[DATA_W-1:0];
        mul_cv   = !mulh_q && (mul_next[2*DATA_W-1:DATA_W] != '0);
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        flags_d    = flags_clr ? 4'b0000 : flags_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mulh_d     = mulh_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        acc_d   = {{DATA_W{1'b0}}, req_b};
                        mcand_d = req_a;
                        mulh_d  = (req_func == F_MULH);
                        cnt_d   = '0;
                        state_d = MUL_BUSY;
                    end else begin
                        state_d    = DONE;
                        rsp_data_d = alu_res;
                        rsp_err_d  = illegal;
                        if (!illegal) begin
                            flags_d = {alu_res == '0, alu_res[DATA_W-1], alu_c, alu_v};
                        end
                    end
                end
            end
            MUL_BUSY: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d    = DONE;
                    rsp_data_d = mul_res;
                    rsp_err_d  = 1'b0;
                    flags_d    = {mul_res == '0, mul_res[DATA_W-1], mul_cv, mul_cv};
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            flags_q    <= 4'b0000;
            acc_q      <= '0;
            mcand_q    <= '0;
            mulh_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            flags_q    <= flags_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mulh_q     <= mulh_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc: hand-computed results, flags, latency,
// backpressure, flag clear, illegal ops and reset during a multiply.
module tb_alu_mc;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_func;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] flags;
    logic       flags_clr;

    int checkCount;
    int passCount;

    alu_mc #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_func  (req_func),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .flags     (flags),
        .flags_clr (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issue one op, wait (bounded) for its response, check it, then take it.
    task automatic applyStimulus(input string tag, input logic [3:0] func, input logic [7:0] a,
                                 input logic [7:0] b, input logic [7:0] expData,
                                 input logic [3:0] expFlags, input logic expErr,
                                 input int expLat, input logic clr);
        int lat;
        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_func  = func;
        req_a     = a;
        req_b     = b;
        flags_clr = clr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flags_clr = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, " data"}, 32'(rsp_data), 32'(expData));
        checkOutput({tag, " err"}, 32'(rsp_err), 32'(expErr));
        checkOutput({tag, " flags"}, 32'(flags), 32'(expFlags));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput({tag, " req_ready after rsp"}, 32'(req_ready), 32'd1);
        checkOutput({tag, " rsp_valid after rsp"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int seen;
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_func   = 4'd0;
        req_a      = 8'h00;
        req_b      = 8'h00;
        rsp_ready  = 1'b0;
        flags_clr  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("reset flags", 32'(flags), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("req_ready after reset", 32'(req_ready), 32'd1);

        //               tag            func   a      b      data   flags    err lat clr
        applyStimulus("ADD ff+01",     4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 0, 0);
        applyStimulus("ADC 10+20+C",   4'd6,  8'h10, 8'h20, 8'h31, 4'b0000, 0, 0, 0);
        applyStimulus("SUB 80-01",     4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 0, 0, 0);
        applyStimulus("ADD ff+01 b",   4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 0, 0);
        applyStimulus("SBC 00-00-C",   4'd7,  8'h00, 8'h00, 8'hFF, 4'b0110, 0, 0, 0);
        applyStimulus("ADD 7f+01",     4'd0,  8'h7F, 8'h01, 8'h80, 4'b0101, 0, 0, 0);
        applyStimulus("AND",           4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0, 0, 0);
        applyStimulus("OR",            4'd3,  8'hF0, 8'h0F, 8'hFF, 4'b0100, 0, 0, 0);
        applyStimulus("XOR",           4'd4,  8'hAA, 8'hAA, 8'h00, 4'b1000, 0, 0, 0);
        applyStimulus("INV",           4'd5,  8'h55, 8'h00, 8'hAA, 4'b0100, 0, 0, 0);
        applyStimulus("MUL 0f*11",     4'd11, 8'h0F, 8'h11, 8'hFF, 4'b0100, 0, 8, 0);
        applyStimulus("MUL 10*10",     4'd11, 8'h10, 8'h10, 8'h00, 4'b1011, 0, 8, 0);
        applyStimulus("MULH 10*10",    4'd12, 8'h10, 8'h10, 8'h01, 4'b0000, 0, 8, 0);
        applyStimulus("MULH ff*ff",    4'd12, 8'hFF, 8'hFF, 8'hFE, 4'b0100, 0, 8, 0);
        applyStimulus("MUL ff*ff",     4'd11, 8'hFF, 8'hFF, 8'h01, 4'b0011, 0, 8, 0);
        applyStimulus("SRA 81>>1",     4'd10, 8'h81, 8'h01, 8'hC0, 4'b0110, 0, 0, 0);
        applyStimulus("SHL 81 by 0",   4'd8,  8'h81, 8'h08, 8'h81, 4'b0100, 0, 0, 0);
        applyStimulus("SHR 81>>1",     4'd9,  8'h81, 8'h01, 8'h40, 4'b0010, 0, 0, 0);
        applyStimulus("SHL 03<<7",     4'd8,  8'h03, 8'h07, 8'h80, 4'b0110, 0, 0, 0);
        applyStimulus("SUB 05-07",     4'd1,  8'h05, 8'h07, 8'hFE, 4'b0110, 0, 0, 0);

        // Backpressure: response held for 5 cycles.
        @(negedge clk);
        req_valid = 1'b1;
        req_func  = 4'd0;
        req_a     = 8'h03;
        req_b     = 8'h04;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp rsp_data", 32'(rsp_data), 32'h07);
            checkOutput("bp req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("bp flags", 32'(flags), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("bp release req_ready", 32'(req_ready), 32'd1);
        checkOutput("bp release rsp_valid", 32'(rsp_valid), 32'd0);

        // Illegal op leaves flags alone.
        applyStimulus("ADD ff+01 c",   4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 0, 0);
        applyStimulus("illegal f",     4'd15, 8'h12, 8'h34, 8'h00, 4'b1010, 1, 0, 0);

        // Standalone clear, then clear colliding with a flag write.
        @(negedge clk);
        flags_clr = 1'b1;
        @(posedge clk);
        #1;
        flags_clr = 1'b0;
        checkOutput("flags_clr alone", 32'(flags), 32'd0);
        applyStimulus("SUB 80-01 b",   4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001, 0, 0, 0);
        applyStimulus("ADD with clr",  4'd0,  8'hFF, 8'h01, 8'h00, 4'b1010, 0, 0, 1);

        // Reset in the middle of a multiply.
        applyStimulus("MUL ff*ff b",   4'd11, 8'hFF, 8'hFF, 8'h01, 4'b0011, 0, 8, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_func  = 4'd11;
        req_a     = 8'hFF;
        req_b     = 8'hFF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("mul busy req_ready", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst mid flags", 32'(flags), 32'd0);
        checkOutput("rst mid rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst mid req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1;
        end
        checkOutput("no rsp after abort", 32'(seen), 32'd0);

        applyStimulus("ADC after rst", 4'd6,  8'h01, 8'h01, 8'h02, 4'b0000, 0, 0, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
